// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//   Byte-stream program loader. This block drives the write side of the
//   RISCV_top instruction memory. It receives a framed program image over a
//   valid/ready byte interface and writes 32-bit words to IMEM at byte
//   addresses 0, 4, 8, and so on. It holds the core in reset until a frame
//   has loaded and its checksum matches, and then it releases the core.
//
//   Frame format: SYNC, LEN_LO, LEN_HI, 4*LEN data bytes, CSUM
//     - Data bytes are little-endian within each word.
//     - CSUM is the XOR of LEN_LO, LEN_HI and every data byte.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   rx_valid_i      rx_data_i holds a byte
//   rx_data_i       incoming byte
//   rx_ready_o      loader accepts a byte (transfer = valid & ready)
//   imem_we_o       one-cycle IMEM write strobe
//   imem_addr_o     IMEM byte address (word index * 4)
//   imem_wdata_o    instruction word
//   core_rst_o      active-high reset to the core
//   load_done_o     frame loaded and checksum correct
//   load_err_o      length or checksum error
//   words_loaded_o  words written in the current or last frame
//
// States
//   state  | meaning
//   IDLE   | waiting for SYNC; all other bytes are dropped
//   LEN0   | capture LEN_LO
//   LEN1   | capture LEN_HI and range-check the length
//   DATA   | assemble the next word from 4 bytes
//   WR     | one-cycle IMEM write, rx_ready low
//   CSUM   | compare the checksum byte with the running XOR
//   DONE   | image accepted, core released; SYNC restarts
//   ERR    | length or checksum failure, core held; SYNC restarts
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int          ADDR_W    = 32,
    parameter int          MAX_WORDS = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_rst_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [15:0]       words_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WR,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        idx_q, idx_d;
    logic [15:0]        words_q, words_d;
    logic [7:0]         xor_q, xor_d;
    logic [31:0]        word_q, word_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic               rdy_q, rdy_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               core_rst_q, core_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               take;
    logic [15:0]        len_full;
    logic [31:0]        word_next;
    logic               is_sync;

    assign take      = rx_valid_i & rdy_q;
    assign len_full  = {rx_data_i, len_lo_q};
    assign word_next = {rx_data_i, word_q[31:8]};
    assign is_sync   = (rx_data_i == SYNC_BYTE);

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        idx_d    = idx_q;
        words_d  = words_q;
        xor_d    = xor_q;
        word_d   = word_q;
        bcnt_d   = bcnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (take && is_sync) begin
                    state_d = S_LEN0;
                    idx_d   = '0;
                    words_d = '0;
                    xor_d   = '0;
                    bcnt_d  = '0;
                end
            end
            S_LEN0: begin
                if (take) begin
                    len_lo_d = rx_data_i;
                    xor_d    = xor_q ^ rx_data_i;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (take) begin
                    len_d = len_full;
                    xor_d = xor_q ^ rx_data_i;
                    if ({16'd0, len_full} > 32'(MAX_WORDS)) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    word_d = word_next;
                    xor_d  = xor_q ^ rx_data_i;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Register the write so the strobe, address and data
                        // are all valid during the WR cycle.
                        state_d = S_WR;
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'({idx_q, 2'b00});
                        wdata_d = word_next;
                    end
                end
            end
            S_WR: begin
                idx_d   = idx_q + 16'd1;
                words_d = words_q + 16'd1;
                if ((idx_q + 16'd1) < len_q) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (take) begin
                    if (rx_data_i == xor_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The status outputs follow the next state, so they line up with
        // the state register on the same edge.
        rdy_d      = (state_d != S_WR);
        core_rst_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            len_lo_q   <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            words_q    <= '0;
            xor_q      <= '0;
            word_q     <= '0;
            bcnt_q     <= '0;
            rdy_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            words_q    <= words_d;
            xor_q      <= xor_d;
            word_q     <= word_d;
            bcnt_q     <= bcnt_d;
            rdy_q      <= rdy_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready_o     = rdy_q;
    assign imem_we_o      = we_q;
    assign imem_addr_o    = addr_q;
    assign imem_wdata_o   = wdata_q;
    assign core_rst_o     = core_rst_q;
    assign load_done_o    = done_q;
    assign load_err_o     = err_q;
    assign words_loaded_o = words_q;

endmodule
